// File: rtl/stream_accum_pkg.sv
// Shared types and defaults for the stream accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stream_accum_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    _state_idle  = 2'd0,
    _state_run   = 2'd1,
    _state_drain = 2'd2,
    _state_done  = 2'd3
  } state_t;

endpackage

// File: rtl/stream_accum.sv
// Accumulates a signed input stream into a running sum and count, one value per cycle.
// Latency: 1 cycle from input handshake to _valid/_out0/_out1; _done one cycle after the final drain.
// Backpressure: _in_ready drops while an output is held unconsumed (_valid && !_ready).
module stream_accum
  import stream_accum_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                    _clock,
  input  logic                    _reset_n,
  input  logic                    _start,
  input  logic signed [WIDTH-1:0] _in_data,
  input  logic                    _in_valid,
  output logic                    _in_ready,
  input  logic                    _in_done,
  input  logic                    _ready,
  output logic                    _valid,
  output logic                    _done,
  output logic signed [WIDTH-1:0] _out0,
  output logic [31:0]             _out1
);

  state_t                  state;
  state_t                  state_nxt;
  logic                    done_nxt;
  logic                    hs;
  logic signed [WIDTH-1:0] sum;
  logic signed [WIDTH-1:0] sum_nxt;
  logic [31:0]             count;
  logic [31:0]             count_nxt;

  // Accept only while running, never in a _start cycle, and only when the output slot is free or draining.
  assign _in_ready = (state == _state_run) && !_start && (!_valid || _ready);
  assign hs        = _in_valid && _in_ready;
  assign sum_nxt   = sum + _in_data;
  assign count_nxt = count + 32'd1;

  // Next-state and end-of-stream pulse decode; _start overrides every state.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    if (_start) begin
      state_nxt = _state_run;
    end else begin
      case (state)
        _state_idle: begin
          state_nxt = _state_idle;
        end
        _state_run: begin
          if (_in_done) state_nxt = _state_drain;
        end
        _state_drain: begin
          if (!_valid || _ready) state_nxt = _state_done;
        end
        _state_done: begin
          if (!_valid && _ready) begin
            state_nxt = _state_idle;
            done_nxt  = 1'b1;
          end
        end
        default: begin
          state_nxt = _state_idle;
        end
      endcase
    end
  end

  // State register and registered _done pulse.
  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      state <= _state_idle;
      _done <= 1'b0;
    end else begin
      state <= state_nxt;
      _done <= done_nxt;
    end
  end

  // Accumulators and output register; a new handshake refills the slot, otherwise _ready empties it.
  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      sum    <= '0;
      count  <= '0;
      _out0  <= '0;
      _out1  <= '0;
      _valid <= 1'b0;
    end else if (_start) begin
      sum    <= '0;
      count  <= '0;
      _out0  <= '0;
      _out1  <= '0;
      _valid <= 1'b0;
    end else if (hs) begin
      sum    <= sum_nxt;
      count  <= count_nxt;
      _out0  <= sum_nxt;
      _out1  <= count_nxt;
      _valid <= 1'b1;
    end else if (_ready) begin
      _valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_accum.sv
// Self-checking bench for stream_accum against a queue-based scoreboard.
// Latency: checks outputs one cycle after each accepted input.
// Backpressure: drives random and toggling _ready patterns.
module tb_stream_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_done;
  logic        ready;
  logic        valid;
  logic        done;
  logic [31:0] out0;
  logic [31:0] out1;

  int          tests = 0;
  int          fails = 0;

  // Scoreboard: every accepted value yields exactly one (sum, count) output, consumed in order.
  logic [31:0] q_sum[$];
  logic [31:0] q_cnt[$];
  logic [31:0] m_sum = '0;
  logic [31:0] m_cnt = '0;
  bit          streaming = 1'b0;
  int          done_cnt = 0;
  logic [31:0] done_o0 = 'x;
  logic [31:0] done_o1 = 'x;
  bit          rtog = 1'b0;

  stream_accum dut (
    ._clock    (clk),
    ._reset_n  (rst_n),
    ._start    (start),
    ._in_data  (in_data),
    ._in_valid (in_valid),
    ._in_ready (in_ready),
    ._in_done  (in_done),
    ._ready    (ready),
    ._valid    (valid),
    ._done     (done),
    ._out0     (out0),
    ._out1     (out1)
  );

  always #5 clk = ~clk;

  // One clock cycle: drive at negedge, check just after, update the scoreboard for the coming posedge.
  task automatic cyc(input logic v, input logic [31:0] d, input logic dn, input logic rdy,
                     input logic st, output logic acc);
    logic exp_ir;
    in_valid = v;
    in_data  = d;
    in_done  = dn;
    ready    = rdy;
    start    = st;
    #1;
    exp_ir = streaming && !st && (q_sum.size() == 0 || rdy);
    tests++;
    if (in_ready !== exp_ir) begin
      fails++;
      $display("FAIL in_ready: got %b want %b at %0t", in_ready, exp_ir, $time);
    end
    tests++;
    if (valid !== (q_sum.size() != 0)) begin
      fails++;
      $display("FAIL valid: got %b want %b at %0t", valid, (q_sum.size() != 0), $time);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_o0 = out0;
      done_o1 = out1;
      tests++;
      if (streaming || q_sum.size() != 0) begin
        fails++;
        $display("FAIL done_early: got done=1 want 0 (streaming=%0d pending=%0d) at %0t",
                 streaming, q_sum.size(), $time);
      end
    end
    acc = v && (in_ready === 1'b1);
    if (st) begin
      q_sum.delete();
      q_cnt.delete();
      m_sum     = '0;
      m_cnt     = '0;
      streaming = 1'b1;
      done_cnt  = 0;
    end else begin
      if (valid === 1'b1 && rdy && q_sum.size() != 0) begin
        tests++;
        if (out0 !== q_sum[0] || out1 !== q_cnt[0]) begin
          fails++;
          $display("FAIL output: got sum=%h cnt=%0d want sum=%h cnt=%0d at %0t",
                   out0, out1, q_sum[0], q_cnt[0], $time);
        end
        void'(q_sum.pop_front());
        void'(q_cnt.pop_front());
      end
      if (acc) begin
        m_sum = m_sum + d;
        m_cnt = m_cnt + 32'd1;
        q_sum.push_back(m_sum);
        q_cnt.push_back(m_cnt);
      end
      if (dn) streaming = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic feed(input logic [31:0] d, input logic dn, input bit tog);
    logic a;
    int   n;
    a = 1'b0;
    n = 0;
    while (!a && n < 20) begin
      if (tog) rtog = !rtog;
      else rtog = 1'b1;
      cyc(1'b1, d, dn, rtog, 1'b0, a);
      n++;
    end
    if (!a) begin
      tests++;
      fails++;
      $display("FAIL feed_timeout: got no accept want accept of %h", d);
    end
  endtask

  task automatic wait_done(input logic [31:0] es, input logic [31:0] ec, input string name);
    logic a;
    int   n;
    n = 0;
    while (done_cnt == 0 && n < 40) begin
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, a);
      n++;
    end
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, a);
    tests++;
    if (done_cnt != 1) begin
      fails++;
      $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt);
    end
    tests++;
    if (done_o0 !== es || done_o1 !== ec) begin
      fails++;
      $display("FAIL %s final: got sum=%h cnt=%0d want sum=%h cnt=%0d", name, done_o0, done_o1, es, ec);
    end
  endtask

  task automatic begin_stream();
    logic a;
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, a);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    in_done  = 1'b0;
    ready    = 1'b0;
    #3;
    tests++;
    if (out0 !== 32'd0 || out1 !== 32'd0 || valid !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got out0=%h out1=%h valid=%b done=%b in_ready=%b want all 0",
               out0, out1, valid, done, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fib(input bit tog, input string name);
    logic        a;
    logic [31:0] f[10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
    begin_stream();
    foreach (f[i]) feed(f[i], 1'b0, tog);
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, a);
    wait_done(32'd88, 32'd10, name);
  endtask

  task automatic test_done_with_hs();
    begin_stream();
    feed(32'd1, 1'b0, 1'b0);
    feed(32'd2, 1'b0, 1'b0);
    feed(32'd3, 1'b0, 1'b0);
    feed(32'd4, 1'b0, 1'b0);
    feed(32'd0, 1'b0, 1'b0);
    feed(32'd7, 1'b1, 1'b0);
    wait_done(32'd17, 32'd6, "done_with_hs");
  endtask

  task automatic test_empty();
    logic a;
    begin_stream();
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, a);
    wait_done(32'd0, 32'd0, "empty");
  endtask

  task automatic test_wrap();
    logic a;
    begin_stream();
    feed(32'h7FFF_FFFF, 1'b0, 1'b0);
    feed(32'h0000_0001, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, a);
    wait_done(32'h8000_0000, 32'd2, "wrap");
  endtask

  task automatic test_restart();
    logic a;
    begin_stream();
    feed(32'd4, 1'b0, 1'b0);
    feed(32'd5, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, a);
    cyc(1'b1, 32'd100, 1'b0, 1'b0, 1'b1, a);
    feed(32'd2, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, a);
    wait_done(32'd2, 32'd1, "restart");
  endtask

  task automatic test_reset_midstream();
    logic a;
    begin_stream();
    feed(32'd5, 1'b0, 1'b0);
    feed(32'd6, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (out0 !== 32'd0 || out1 !== 32'd0 || valid !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_midstream: got out0=%h out1=%h valid=%b done=%b in_ready=%b want all 0",
               out0, out1, valid, done, in_ready);
    end
    q_sum.delete();
    q_cnt.delete();
    m_sum     = '0;
    m_cnt     = '0;
    streaming = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 32'd3, 1'b0, 1'b1, 1'b0, a);
    begin_stream();
    feed(32'd9, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, a);
    wait_done(32'd9, 32'd1, "reset_restart");
  endtask

  task automatic test_random();
    logic a;
    logic v;
    logic r;
    logic dn;
    int   nv;
    int   k;
    int   n;
    for (int s = 0; s < 8; s++) begin
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, a);
      cyc(1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b1, 1'b1, a);
      nv = $urandom_range(0, 12);
      k  = 0;
      n  = 0;
      while (k < nv && n < 300) begin
        v  = 1'($urandom_range(0, 1));
        r  = ($urandom_range(0, 3) != 0);
        dn = (k == nv - 1) && v && ($urandom_range(0, 1) == 1);
        cyc(v, $urandom, dn, r, 1'b0, a);
        if (a) k++;
        n++;
        if (dn) break;
      end
      if (streaming) cyc(1'b0, '0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, a);
      repeat (2) cyc(1'b0, '0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, a);
      wait_done(m_sum, m_cnt, "random");
    end
  endtask

  initial begin
    test_reset();
    test_fib(1'b0, "fib");
    test_fib(1'b1, "fib_toggle");
    test_done_with_hs();
    test_empty();
    test_wrap();
    test_restart();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish by 500000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/stream_accum.md
STREAM_ACCUM -- requirements
Module: stream_accum

Interface
REQ-001 Parameter: WIDTH, 32, bit width of input data and output sum.
REQ-002 Port: _clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: _reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: _start  input  1  pulse high one cycle to clear accumulators and begin consuming.
REQ-005 Port: _in_data  input  WIDTH signed  upstream generator output value.
REQ-006 Port: _in_valid  input  1  upstream value valid.
REQ-007 Port: _in_ready  output  1  this block accepts _in_data this cycle.
REQ-008 Port: _in_done  input  1  upstream single-cycle end-of-stream pulse.
REQ-009 Port: _ready  input  1  downstream consumer ready for output.
REQ-010 Port: _valid  output  1  _out0/_out1 valid.
REQ-011 Port: _done  output  1  single-cycle pulse when stream fully processed.
REQ-012 Port: _out0  output  WIDTH signed  running sum including latest accepted value.
REQ-013 Port: _out1  output  32 unsigned  count of values accepted since _start.

Function
REQ-014 States SHALL be exactly: _state_idle, _state_run, _state_drain, _state_done.
REQ-015 Input handshake occurs when _in_valid && _in_ready on a rising edge.
REQ-016 _in_ready SHALL be high iff state == _state_run and (!_valid || _ready), combinational from registered state.
REQ-017 On handshake: sum <= sum + _in_data (WIDTH-bit two's-complement wrap), count <= count + 1, _out0/_out1 <= new values, _valid <= 1 at next edge (latency 1 cycle).
REQ-018 Throughput SHALL be one value per cycle while _in_valid and _ready are both held high.
REQ-019 _valid SHALL clear at an edge where _ready is high and no new handshake occurs; _out0/_out1 SHALL hold while _valid && !_ready.
REQ-020 _start (any state): sum, count, _out0, _out1 <= 0, _valid <= 0, state <= _state_run; _in_ready low that cycle, any concurrent _in_valid ignored.
REQ-021 _in_done in _state_run: state <= _state_drain; a handshake in the same cycle SHALL still be accepted and counted.
REQ-022 _in_done outside _state_run SHALL be ignored.
REQ-023 _state_drain: wait until !_valid || _ready, then state <= _state_done; no further inputs accepted.
REQ-024 _state_done: when !_valid && _ready, pulse _done for one cycle and go to _state_idle; else remain.
REQ-025 _done SHALL be low in every cycle except the REQ-024 pulse.
REQ-026 Empty stream (_in_done with zero handshakes): _valid never asserts; _done pulses with _out0 = 0, _out1 = 0.
REQ-027 _state_idle: no handshakes, outputs hold last values, _valid cleared per REQ-019.
REQ-028 _out1 SHALL wrap modulo 2^32.

Reset
REQ-029 _reset_n low SHALL immediately force state = _state_idle, _valid = 0, _done = 0, _out0 = 0, _out1 = 0, sum = 0, count = 0, independent of _clock.
REQ-030 Reset SHALL dominate _start; a stream interrupted mid-run is discarded and requires a new _start.

Structure
REQ-031 Shared package SHALL hold the state enum typedef and default WIDTH constant.
REQ-032 Single flat module; no sub-module required.

Verification
REQ-033 Fibonacci stream 0,1,1,2,3,5,8,13,21,34 then _in_done, _ready=1 -> _out0 sequence 0,1,2,4,7,12,20,33,54,88, _out1 1..10, one _done pulse.
REQ-034 Same stream with _ready toggling 1/0 each cycle -> identical _out0/_out1 sequence, no value dropped or duplicated, _in_ready low while _valid && !_ready.
REQ-035 _in_done coincident with handshake of 7 after 5 prior values summing 10 -> final _out0 = 17, _out1 = 6, then _done.
REQ-036 _start then immediate _in_done -> no _valid, _done pulse with _out0 = 0, _out1 = 0.
REQ-037 Inputs 0x7FFFFFFF then 1 -> _out0 = 0x7FFFFFFF then 0x80000000 (wrap), _out1 = 2.
REQ-038 _reset_n low between edges mid-stream -> outputs 0 before next edge; new _start restarts count from 1.
